// File: rtl/bram_rmw_pkg.sv
// bram_rmw_pkg: shared op and state encodings for the BRAM read-modify-write controller
package bram_rmw_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_READ = 2'd1, OP_READ_CLR = 2'd2, OP_WRITE = 2'd3} op_e;
  typedef enum logic [1:0] {INIT, IDLE, MOD, RSP} state_e;
endpackage

// File: rtl/bram_rmw_add.sv
// bram_rmw_add: D-bit unsigned adder, saturating when BRAM_RMW_SAT_EN is defined, wrapping otherwise
module bram_rmw_add #(
  parameter int D = 18
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  output logic [D-1:0] y
);
  logic [D:0] sum;
  // widen by one bit so the carry tells us whether the result overflowed
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
`ifdef BRAM_RMW_SAT_EN
    y = sum[D] ? '1 : sum[D-1:0];
`else
    y = sum[D-1:0];
`endif
  end
endmodule

// File: rtl/bram_rmw_ctrl.sv
// bram_rmw_ctrl: zero-filling read-modify-write controller for a single-port read-first BRAM
module bram_rmw_ctrl
  import bram_rmw_pkg::*;
#(
  parameter int D = 18,
  parameter int A = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [A-1:0] in_addr,
  input  logic [D-1:0] in_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [D-1:0] rsp_data,
  output logic         init_done,
  output logic         ram_en,
  output logic         ram_we,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_di,
  input  logic [D-1:0] ram_dout
);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [A-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [D-1:0] data_q, data_d, rsp_data_q, rsp_data_d, sum;
  logic in_ready_q, in_ready_d, rsp_valid_q, rsp_valid_d, init_done_q, init_done_d;
  logic init, acc, wr, rd_op;

  bram_rmw_add #(.D(D)) u_add (.a(ram_dout), .b(data_q), .y(sum));

  // next state, command capture and RAM port drive; a write pending during rst is suppressed
  always_comb begin
    init = state_q == INIT;
    acc = state_q == IDLE && in_valid;
    rd_op = op_q == OP_READ || op_q == OP_READ_CLR;
    wr = state_q == MOD && op_q != OP_READ;
    state_d = init ? (&cnt_q ? IDLE : INIT) :
              state_q == IDLE ? (in_valid ? MOD : IDLE) :
              state_q == MOD ? (rd_op ? RSP : IDLE) :
              (rsp_ready ? IDLE : RSP);
    cnt_d = init ? cnt_q + A'(1) : '0;
    op_d = acc ? op_e'(in_op) : op_q;
    addr_d = acc ? in_addr : addr_q;
    data_d = acc ? in_data : data_q;
    rsp_data_d = state_q == MOD && rd_op ? ram_dout : rsp_data_q;
    in_ready_d = state_d == IDLE;
    rsp_valid_d = state_d == RSP;
    init_done_d = state_d != INIT;
    ram_en = init || acc || (wr && !rst);
    ram_we = init || (wr && !rst);
    ram_addr = init ? cnt_q : state_q == IDLE ? in_addr : addr_q;
    ram_di = wr && op_q == OP_ADD ? sum : wr && op_q == OP_WRITE ? data_q : '0;
  end

  // state and registered outputs; rst wins over everything and restarts the zero-fill
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      op_q <= OP_ADD;
      addr_q <= '0;
      data_q <= '0;
      rsp_data_q <= '0;
      in_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rsp_data_q <= rsp_data_d;
      in_ready_q <= in_ready_d;
      rsp_valid_q <= rsp_valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign init_done = init_done_q;
endmodule

// File: doc/bram_rmw_ctrl.md
# bram_rmw_ctrl

Read-modify-write controller that sits directly upstream of a single-port read-first block RAM and owns all of its port signals. It accepts accumulate/read/clear/write commands over a valid/ready interface and performs each as a single RAM read followed by a single RAM write. It returns read data over a valid/ready response channel. After every reset it zero-fills the whole RAM before accepting commands, so the RAM needs no initial contents. Typical use is histogram or event-counter tables.

## Interface
- D, 18, RAM word width in bits (data, delta, response)
- A, 10, RAM address width; table depth 2**A
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_op  in  2  0=ADD, 1=READ, 2=READ_CLR, 3=WRITE
- in_addr  in  A  target entry
- in_data  in  D  ADD: unsigned delta; WRITE: new value; else ignored
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_data  out  D  entry value before the operation (READ, READ_CLR only)
- init_done  out  1  high once zero-fill is complete
- ram_en, ram_we  out  1 each  RAM enable / write enable
- ram_addr  out  A  RAM address
- ram_di  out  D  RAM write data
- ram_dout  in  D  RAM read data, valid the cycle after a read-enable edge

## Operation
- State machine states: INIT, IDLE, MOD, RSP.
- INIT:
  - counter cnt runs 0..2**A-1, one entry per cycle.
  - Each cycle drives ram_en=1, ram_we=1, ram_addr=cnt, ram_di=0.
  - After cnt=2**A-1 the state moves to IDLE and init_done goes to 1.
- IDLE:
  - in_ready=1.
  - On acceptance, combinationally drives ram_en=1, ram_we=0, ram_addr=in_addr.
  - Registers op, addr and data, then moves to MOD.
- MOD (in_ready=0): ram_dout holds old value V; ram_addr=addr.
  - ADD: write V+data (see Configuration), next state IDLE.
  - WRITE: write data, next state IDLE.
  - READ: ram_en=0, capture V into rsp_data, next state RSP.
  - READ_CLR: write 0, capture V, next state RSP.
- RSP:
  - rsp_valid=1; rsp_data is stable.
  - On rsp_ready the state moves to IDLE on the next edge.
- In all other cycles ram_en=0, ram_we=0.
- Arithmetic is unsigned D-bit; the sum is computed at D+1 bits, then reduced to D.
- Because each write completes before the next read can issue, back-to-back commands to the same address see fully updated data. No forwarding is required.

## Timing
- Reset values: in_ready=0, rsp_valid=0, rsp_data=0, init_done=0, state=INIT, cnt=0. ram_en/ram_we follow state, so they are 1 during INIT.
- Zero-fill takes 2**A cycles after rst deasserts; in_ready first rises in cycle 2**A.
- Command accepted at edge T:
  - write issues in cycle T+1;
  - in_ready returns in cycle T+2 for ADD/WRITE.
  - Peak throughput is one command per 2 cycles.
- READ/READ_CLR accepted at T: rsp_valid rises in cycle T+2.
  - With rsp_ready=1, in_ready returns at T+3.
- rsp_ready low holds rsp_valid and rsp_data indefinitely; no further command is accepted meanwhile.
- rst asserted in any state, including mid-INIT, MOD or RSP:
  - the next edge returns to INIT with cnt=0;
  - any in-flight write and any pending response are dropped;
  - the full zero-fill restarts.
- rst has priority over every other event on the same edge.

## Configuration
- Macro BRAM_RMW_SAT_EN.
- Defined: ADD saturates; if V+data ≥ 2**D, the value written is 2**D-1.
- Undefined: ADD wraps modulo 2**D.
- No other behaviour depends on the macro.

## Structure
- Package bram_rmw_pkg holds:
  - the op encoding (OP_ADD=0, OP_READ=1, OP_READ_CLR=2, OP_WRITE=3) as an enumerated 2-bit type;
  - the state enum.
- Sub-module bram_rmw_add:
  - D-bit unsigned adder;
  - contains the BRAM_RMW_SAT_EN saturate/wrap selection, so the macro appears in one place only.
- The RAM is instantiated by the parent, not inside this block.

## Test plan
- Reset, D=18, A=10:
  - ram_we=1 for exactly 1024 cycles with addresses 0..1023 and di=0;
  - init_done and in_ready rise in cycle 1024.
- WRITE addr 5 = 100, ADD addr 5 delta 23, READ addr 5 → rsp_data=123. Write at addr 5 is observed in cycle T+1 of each command.
- WRITE addr 7 = 0x3FFF0, ADD addr 7 delta 0x20, then READ:
  - rsp_data=0x3FFFF with BRAM_RMW_SAT_EN;
  - rsp_data=0x00010 without.
- READ_CLR addr 9 holding 42 → rsp_data=42; following READ addr 9 → 0.
- Hold rsp_ready=0 for 10 cycles after a READ → rsp_valid and rsp_data stable and in_ready=0 throughout; release → in_ready=1 one cycle later.
- Assert rst during MOD of an ADD, then again at cnt=500 of INIT:
  - no response appears;
  - zero-fill restarts from address 0;
  - all entries read 0 afterwards.
